sm83_idu_seq: RTL



---
 rtl/sm83_idu_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sm83_idu_seq.sv
// SM83 IDU bit-cell sequencer: drives precharge/evaluate/drive strobes to the
// IDU column and produces the behavioural 16-bit inc/dec result with flags.
module sm83_idu_seq #(
    parameter int WIDTH       = 16,
    parameter int PCH_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    output logic             ready,
    input  logic [1:0]       op,
    input  logic [1:0]       dest,
    input  logic [WIDTH-1:0] src,
    output logic             pch_n,
    output logic             aoi_buf_ena,
    output logic             zero_ena,
    output logic             buf_ena_n,
    output logic             drive_a,
    output logic             drive_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             wrap,
    output logic             done
);

    localparam int CNT_MAX = (PCH_CYCLES > EVAL_CYCLES) ? PCH_CYCLES : EVAL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PCH_LOAD  = CNT_W'(PCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PCH   = 2'd1,
        S_EVAL  = 2'd2,
        S_DRIVE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic               w_accept;
    logic               w_last_eval;

    logic [1:0]         r_op;
    logic [1:0]         r_dest;
    logic [WIDTH-1:0]   r_src;

    logic               r_ready;
    logic               r_pch_n;
    logic               r_aoi_buf_ena;
    logic               r_zero_ena;
    logic               r_buf_ena_n;
    logic               r_drive_a;
    logic               r_drive_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_wrap;
    logic               r_done;

    logic [WIDTH-1:0]   w_result;
    logic               w_wrap;

    assign w_accept = (r_state == S_IDLE) && req;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_last_eval  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = S_PCH;
                    w_next_cnt   = PCH_LOAD;
                end
            end
            S_PCH: begin
                if (r_cnt == '0) begin
                    w_next_state = S_EVAL;
                    w_next_cnt   = EVAL_LOAD;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (r_cnt == '0) begin
                    w_next_state = S_DRIVE;
                    w_next_cnt   = '0;
                    w_last_eval  = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_DRIVE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Operands are frozen at accept so requester-side changes cannot disturb the op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= 2'b00;
            r_dest <= 2'b00;
            r_src  <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_dest <= dest;
            r_src  <= src;
        end
    end

    always_comb begin
        w_result = r_src;
        case (r_op)
            2'b01:   w_result = r_src + WIDTH'(1);
            2'b10:   w_result = r_src - WIDTH'(1);
            default: w_result = r_src;
        endcase
    end

    assign w_wrap = ((r_op == 2'b01) && (&r_src)) ||
                    ((r_op == 2'b10) && (r_src == '0));

    // Strobes are registered from the next state, so each one tracks its state exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready       <= 1'b1;
            r_pch_n       <= 1'b0;
            r_aoi_buf_ena <= 1'b0;
            r_zero_ena    <= 1'b0;
            r_buf_ena_n   <= 1'b1;
            r_drive_a     <= 1'b0;
            r_drive_b     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ready       <= (w_next_state == S_IDLE);
            r_pch_n       <= (w_next_state == S_EVAL);
            r_aoi_buf_ena <= (w_next_state == S_EVAL);
            r_zero_ena    <= (w_next_state == S_EVAL);
            r_buf_ena_n   <= (w_next_state != S_DRIVE);
            r_drive_a     <= (w_next_state == S_DRIVE) && r_dest[0];
            r_drive_b     <= (w_next_state == S_DRIVE) && r_dest[1];
            r_done        <= (w_next_state == S_DRIVE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (w_last_eval) begin
            r_result <= w_result;
            r_zero   <= (w_result == '0);
            r_wrap   <= w_wrap;
        end
    end

    assign ready       = r_ready;
    assign pch_n       = r_pch_n;
    assign aoi_buf_ena = r_aoi_buf_ena;
    assign zero_ena    = r_zero_ena;
    assign buf_ena_n   = r_buf_ena_n;
    assign drive_a     = r_drive_a;
    assign drive_b     = r_drive_b;
    assign result      = r_result;
    assign zero        = r_zero;
    assign wrap        = r_wrap;
    assign done        = r_done;

endmodule
